// File: rtl/dmem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_bus_arbiter
//  Description : Shares the data-memory/IO port between the CPU load/store
//                port and the UART program loader. One access in flight at a
//                time, sequenced IDLE -> ISSUE -> (WAIT) -> DONE.
//                Optional macro LDR_PRIORITY_EN: loader wins every tie
//                (fixed priority); otherwise ties are resolved round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] c_rd_lat = 3'(RD_LAT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_cnt;
    logic       w_any_req;
    logic       w_grant_ldr;

    assign w_any_req = cpu_req | ldr_req;
    assign cpu_stall = cpu_req & ~cpu_ack;

`ifdef LDR_PRIORITY_EN
    // Fixed priority: the loader takes the bus whenever it asks for it.
    always_comb w_grant_ldr = ldr_req;
`else
    logic r_last_served;  // 1 = loader was granted last

    // Round-robin: on a tie, grant whichever requester was not served last.
    always_comb w_grant_ldr = ldr_req & (~cpu_req | ~r_last_served);

    // Remember the last grantee; reset to loader so the CPU wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_served <= 1'b1;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_last_served <= w_grant_ldr;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and state-decoded strobes (strobes drop with async reset).
    always_comb begin
        w_state_nxt = r_state;
        mem_en      = 1'b0;
        cpu_ack     = 1'b0;
        ldr_ack     = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_any_req) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_en      = 1'b1;
                w_state_nxt = mem_we ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == 3'd1) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                cpu_ack     = ~owner;
                ldr_ack     = owner;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: capture winner's request at grant, count read latency,
    // and land read data in the owner's return register only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            ldr_rdata <= '0;
            r_cnt     <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        owner     <= w_grant_ldr;
                        mem_we    <= w_grant_ldr ? ldr_we    : cpu_we;
                        mem_addr  <= w_grant_ldr ? ldr_addr  : cpu_addr;
                        mem_wdata <= w_grant_ldr ? ldr_wdata : cpu_wdata;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= c_rd_lat;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        if (owner) begin
                            ldr_rdata <= mem_rdata;
                        end else begin
                            cpu_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_bus_arbiter
//  Description : Directed self-checking bench for dmem_bus_arbiter (RD_LAT=3).
//                Honours LDR_PRIORITY_EN for the expected grant order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_bus_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 3;
`ifdef LDR_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req, cpu_we, ldr_req, ldr_we;
    logic [ADDR_W-1:0] cpu_addr, ldr_addr, mem_addr;
    logic [DATA_W-1:0] cpu_wdata, ldr_wdata, mem_wdata, mem_rdata;
    logic [DATA_W-1:0] cpu_rdata, ldr_rdata;
    logic              cpu_ack, cpu_stall, ldr_ack, mem_en, mem_we, owner, busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    dmem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        total_cnt++;
        if ({mem_en, mem_we, busy, cpu_ack, ldr_ack, owner} !== 6'b0)
            $display("FAIL reset_ctl: got %b expected 000000", {mem_en, mem_we, busy, cpu_ack, ldr_ack, owner});
        else pass_cnt++;
        total_cnt++;
        if ({mem_addr, mem_wdata} !== 64'h0)
            $display("FAIL reset_mem: got %h expected 0", {mem_addr, mem_wdata});
        else pass_cnt++;
        total_cnt++;
        if ({cpu_rdata, ldr_rdata} !== 64'h0)
            $display("FAIL reset_rdata: got %h expected 0", {cpu_rdata, ldr_rdata});
        else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_cpu_write;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0010; cpu_wdata = 32'hDEAD_BEEF;
        tick();  // cycle 1
        total_cnt++;
        if ({mem_en, mem_we, owner, cpu_ack, busy, cpu_stall} !== 6'b110011)
            $display("FAIL wr_c1_ctl: got %b expected 110011", {mem_en, mem_we, owner, cpu_ack, busy, cpu_stall});
        else pass_cnt++;
        total_cnt++;
        if (mem_addr !== 32'h10 || mem_wdata !== 32'hDEAD_BEEF)
            $display("FAIL wr_c1_bus: got %h/%h expected 00000010/deadbeef", mem_addr, mem_wdata);
        else pass_cnt++;
        tick();  // cycle 2
        total_cnt++;
        if ({cpu_ack, ldr_ack, mem_en, cpu_stall} !== 4'b1000)
            $display("FAIL wr_c2_ack: got %b expected 1000", {cpu_ack, ldr_ack, mem_en, cpu_stall});
        else pass_cnt++;
        cpu_req = 1'b0;
        tick();  // cycle 3
        total_cnt++;
        if ({cpu_ack, busy} !== 2'b00)
            $display("FAIL wr_c3_idle: got %b expected 00", {cpu_ack, busy});
        else pass_cnt++;
    endtask

    task automatic test_ldr_read;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h0000_0040;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) begin
                total_cnt++;
                if ({mem_en, mem_we, owner} !== 3'b101 || mem_addr !== 32'h40)
                    $display("FAIL rd_issue: got %b/%h expected 101/00000040", {mem_en, mem_we, owner}, mem_addr);
                else pass_cnt++;
            end
            if (c == 4) mem_rdata = 32'h1234_5678;
            if (c == 5) mem_rdata = 32'hBAD0_0000;
            total_cnt++;
            if (ldr_ack !== (c == 5))
                $display("FAIL rd_ack_c%0d: got %b expected %b", c, ldr_ack, (c == 5));
            else pass_cnt++;
        end
        total_cnt++;
        if (ldr_rdata !== 32'h1234_5678 || cpu_rdata !== 32'h0 || cpu_ack !== 1'b0)
            $display("FAIL rd_data: got %h/%h/%b expected 12345678/00000000/0", ldr_rdata, cpu_rdata, cpu_ack);
        else pass_cnt++;
        ldr_req = 1'b0;
        tick();
    endtask

    task automatic test_round_robin;
        logic exp_owner;
        int   n;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'hC0C0_0000;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h200; ldr_wdata = 32'h1D1D_0000;
        for (int k = 0; k < 4; k++) begin
            exp_owner = PRIO ? 1'b1 : k[0];
            n = 0;
            do begin
                tick();
                n++;
            end while (mem_en !== 1'b1 && n < 8);
            total_cnt++;
            if (mem_en !== 1'b1 || owner !== exp_owner || mem_addr !== (exp_owner ? 32'h200 : 32'h100))
                $display("FAIL rr_grant%0d: got en=%b owner=%b addr=%h expected en=1 owner=%b", k, mem_en, owner, mem_addr, exp_owner);
            else pass_cnt++;
            tick();  // DONE
            total_cnt++;
            if ({cpu_ack, ldr_ack, cpu_stall} !== {~exp_owner, exp_owner, exp_owner})
                $display("FAIL rr_ack%0d: got %b expected %b", k, {cpu_ack, ldr_ack, cpu_stall}, {~exp_owner, exp_owner, exp_owner});
            else pass_cnt++;
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_read;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
        tick(); tick(); tick();  // cycle 3, waiting for read data
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({mem_en, busy, cpu_ack, ldr_ack} !== 4'b0)
            $display("FAIL rst_abort: got %b expected 0000", {mem_en, busy, cpu_ack, ldr_ack});
        else pass_cnt++;
        cpu_req = 1'b0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            total_cnt++;
            if ({mem_en, busy, cpu_ack, ldr_ack} !== 4'b0)
                $display("FAIL rst_noack%0d: got %b expected 0000", c, {mem_en, busy, cpu_ack, ldr_ack});
            else pass_cnt++;
        end
        cpu_req = 1'b1; cpu_we = 1'b1; ldr_req = 1'b1; ldr_we = 1'b1;
        tick();
        total_cnt++;
        if (mem_en !== 1'b1 || owner !== PRIO)
            $display("FAIL rst_first_tie: got en=%b owner=%b expected en=1 owner=%b", mem_en, owner, PRIO);
        else pass_cnt++;
        tick();
        cpu_req = 1'b0; ldr_req = 1'b0;
        tick();
    endtask

    task automatic test_addr_hold;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h5555_AAAA;
        tick();  // cycle 1
        cpu_addr = 32'h24; cpu_wdata = 32'h0;
        total_cnt++;
        if (mem_addr !== 32'h20 || mem_wdata !== 32'h5555_AAAA || mem_en !== 1'b1)
            $display("FAIL hold_c1: got %h/%h/%b expected 00000020/5555aaaa/1", mem_addr, mem_wdata, mem_en);
        else pass_cnt++;
        tick();  // cycle 2
        total_cnt++;
        if (mem_addr !== 32'h20 || cpu_ack !== 1'b1)
            $display("FAIL hold_c2: got %h/%b expected 00000020/1", mem_addr, cpu_ack);
        else pass_cnt++;
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_idle;
        for (int c = 0; c < 10; c++) begin
            tick();
            total_cnt++;
            if ({mem_en, busy, cpu_ack, ldr_ack} !== 4'b0)
                $display("FAIL idle%0d: got %b expected 0000", c, {mem_en, busy, cpu_ack, ldr_ack});
            else pass_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
        mem_rdata = 32'hBAD0_0000;
        tick(); tick();
        test_reset();
        test_cpu_write();
        test_ldr_read();
        test_round_robin();
        test_reset_mid_read();
        test_addr_hold();
        test_idle();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/dmem_bus_arbiter.md
Name: dmem_bus_arbiter

Overview:
- Shares the single data-memory/IO port between two requesters: the CPU load/store port and the UART program loader.
- Sequences each access through a small FSM. Inserts wait states for the memory read latency. Returns a one-cycle acknowledge plus read data to the winning requester.
- Sits between the requesters and the memory/IO address-decode stage.
- Only one access is in flight at a time.

Parameters:
- ADDR_W, 32, width of the address buses
- DATA_W, 32, width of the data buses
- RD_LAT, 1, data-memory read latency in cycles after the mem_en cycle; legal range 1..4

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  read data to CPU, valid while cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse to CPU
- cpu_stall  out  1  cpu_req & ~cpu_ack, combinational
- ldr_req  in  1  loader access request, held until ldr_ack
- ldr_we  in  1  1=write, 0=read
- ldr_addr  in  ADDR_W  loader address
- ldr_wdata  in  DATA_W  loader write data
- ldr_rdata  out  DATA_W  read data to loader, valid while ldr_ack=1
- ldr_ack  out  1  one-cycle completion pulse to loader
- mem_en  out  1  memory/IO access strobe, one cycle per access
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  registered address to memory/IO decode
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  memory read data
- owner  out  1  0=CPU, 1=loader; current or last grantee
- busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset (async, immediate): state=IDLE; mem_en, mem_we, cpu_ack, ldr_ack, busy = 0; mem_addr, mem_wdata, cpu_rdata, ldr_rdata = 0; owner=0; last_served=1 (loader), so the CPU wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req is high at a rising edge: arbitrate, then register the winner's we/addr/wdata into mem_we/mem_addr/mem_wdata.
  - Set owner to the winner, go to ISSUE.
  - No request: stay in IDLE, mem_en=0.
- Arbitration (default): round-robin.
  - Only one requester high: that one wins.
  - Both high: the requester not equal to last_served wins.
  - last_served updates at grant.
- ISSUE:
  - mem_en=1 for exactly this cycle.
  - Write: go to DONE.
  - Read: load the latency counter with RD_LAT, go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle the counter reaches 1, mem_rdata is valid. At that edge, capture mem_rdata into the owner's rdata register and go to DONE.
- DONE: owner's ack=1 for exactly one cycle; next state IDLE. Requests are not sampled in DONE.
- Latency, counting from the cycle in which req is first sampled high by IDLE as cycle 0:
  - Write: mem_en in cycle 1, ack in cycle 2.
  - Read: mem_en in cycle 1, ack in cycle RD_LAT+2.
  - Back-to-back requests from the same master restart at IDLE; minimum spacing is 3 cycles for writes.
- Address and data are captured at grant. Requester changes after grant are ignored until the next grant.
- Non-owner rdata register and non-owner ack are unaffected by the access.
- A requester keeping req high after its ack is treated as a new request in IDLE. This is legal; it yields back-to-back accesses subject to round-robin.
- Request dropped before ack (protocol violation): the access still completes and ack still pulses.
- Reset mid-operation: aborts immediately; mem_en drops asynchronously; no ack is produced; round-robin history returns to its reset value.
- Widths: no arithmetic on data; the counter is 3 bits.

Optional Feature:
- Macro: LDR_PRIORITY_EN.
- Defined: fixed priority. The loader always wins when both requests are high; last_served is unused. The CPU is stalled for as long as the loader keeps requesting; this is intended for program download.
- Not defined: round-robin as described in Behaviour.

Test Plan:
- CPU write only:
  - Stimulus: RD_LAT=1, cpu_req=1, cpu_we=1, addr=0x0000_0010, wdata=0xDEAD_BEEF sampled in cycle 0.
  - Required: mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF in cycle 1; cpu_ack=1 only in cycle 2; owner=0.
- Loader read:
  - Stimulus: RD_LAT=3, ldr_req read at addr 0x40, memory returns 0x1234_5678 in cycle 4.
  - Required: ldr_ack=1 and ldr_rdata=0x12345678 in cycle 5; cpu_rdata stays 0.
- Simultaneous requests, both held high for 4 accesses:
  - Default build, grant order: CPU, loader, CPU, loader.
  - With LDR_PRIORITY_EN: loader, loader, loader, loader; cpu_stall=1 throughout.
- Reset mid-read:
  - Stimulus: RD_LAT=4, assert rst in cycle 3.
  - Required: mem_en, busy and both acks = 0 immediately; no ack follows; after release, the first tie goes to the CPU.
- Address change after grant:
  - Stimulus: cpu_addr changes from 0x20 to 0x24 in cycle 1.
  - Required: mem_addr remains 0x20 for the whole access.
- Idle bus:
  - Stimulus: no requests for 10 cycles.
  - Required: mem_en=0, busy=0, acks=0 throughout.
